// File: rtl/scc_mem_pkg.sv
// Shared types and constants for the SCC data-memory responder.
package scc_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_WIDTH = 32;

    // Bit positions in the latched fault-reason vector.
    localparam int unsigned FAULT_MISALIGN = 0;
    localparam int unsigned FAULT_RANGE    = 1;
    localparam int unsigned FAULT_CONFLICT = 2;
    localparam int unsigned FAULT_W        = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with byte-write mask and a registered,
// read-enabled output that holds its value between reads.
module dmem_array
    import scc_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [WORD_BYTES-1:0] wmask,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (wmask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: fixed-latency single-word read/write with fault pulses.
// Optional byte-enable write port when DMEM_BYTE_EN_EN is defined.
module data_mem_responder
    import scc_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_read,
    input  logic        data_write,
    output logic [31:0] data_in,
    output logic        data_ready,
    output logic        data_busy,
    output logic        data_fault
`ifdef DMEM_BYTE_EN_EN
    ,
    input  logic [3:0]  data_be
`endif
);

    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [CNT_W-1:0]        lat_init;
    logic                    accept;
    logic [FAULT_W-1:0]      fault_now, fault_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    is_read_q;
    logic [WORD_BYTES-1:0]   be_q;
    logic                    finish;
    logic                    ram_we, ram_re;

    assign fault_now[FAULT_MISALIGN] = |data_addr[1:0];
    assign fault_now[FAULT_RANGE]    = |data_addr[31:ADDR_WIDTH+2];
    assign fault_now[FAULT_CONFLICT] = data_read & data_write;

    // A read/write conflict takes the read latency.
    assign lat_init = data_read ? CNT_W'(READ_LATENCY - 1) : CNT_W'(WRITE_LATENCY - 1);
    assign accept   = (state == IDLE) && (data_read || data_write);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (data_read || data_write) begin
                    state_next = WAIT;
                    cnt_next   = lat_init;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        data_busy  = (state == WAIT);
        data_ready = (state == DONE);
        data_fault = (state == DONE) && (|fault_q);
        finish     = (state == WAIT) && (cnt == '0);
        ram_we     = finish && !is_read_q && !(|fault_q);
        ram_re     = finish &&  is_read_q && !(|fault_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            fault_q   <= '0;
            be_q      <= '0;
        end else if (accept) begin
            addr_q    <= data_addr[ADDR_WIDTH+1:2];
            wdata_q   <= data_out;
            is_read_q <= data_read;
            fault_q   <= fault_now;
`ifdef DMEM_BYTE_EN_EN
            be_q      <= data_be;
`else
            be_q      <= '1;
`endif
        end
    end

    // RAM read register doubles as data_in, so it only moves on a good read.
    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dmem_array (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .wmask (be_q),
        .rdata (data_in)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int unsigned AW    = 8;
    localparam int unsigned RL    = 2;
    localparam int unsigned WL    = 1;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_out = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_in;
    logic        data_ready;
    logic        data_busy;
    logic        data_fault;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]  data_be = '0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_din = '0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_WIDTH    (AW),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_addr  (data_addr),
        .data_out   (data_out),
        .data_read  (data_read),
        .data_write (data_write),
        .data_in    (data_in),
        .data_ready (data_ready),
        .data_busy  (data_busy),
        .data_fault (data_fault)
`ifdef DMEM_BYTE_EN_EN
        ,
        .data_be    (data_be)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input bit disturb, input string tag);
        int unsigned exp_lat;
        int unsigned cycles;
        int unsigned idx;
        bit          exp_fault;
        bit          seen;
        logic [3:0]  be_eff;
`ifdef DMEM_BYTE_EN_EN
        be_eff = be;
`else
        be_eff = 4'hF;
`endif
        exp_lat   = (wr && !rd) ? WL : RL;
        exp_fault = (rd && wr) || (addr % 4 != 0) || (addr >= 4 * DEPTH);
        idx       = addr / 4;

        data_addr  = addr;
        data_out   = wdata;
        data_read  = rd;
        data_write = wr;
`ifdef DMEM_BYTE_EN_EN
        data_be    = be;
`endif
        step();
        data_read  = 1'b0;
        data_write = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        while (cycles <= exp_lat + 3) begin
            if (data_ready) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if (data_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_in_wait: got %b, expected 1 (cycle %0d)", tag, data_busy, cycles);
            end
            if (disturb) begin
                data_addr  = $urandom;
                data_out   = $urandom;
                data_write = 1'($urandom_range(0, 1));
                data_read  = 1'($urandom_range(0, 1));
            end
            step();
            cycles++;
        end
        data_read  = 1'b0;
        data_write = 1'b0;

        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s ready_timeout: no data_ready within %0d cycles, expected after %0d", tag, cycles, exp_lat);
        end else begin
            checks++;
            if (cycles != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, expected %0d", tag, cycles, exp_lat);
            end
            checks++;
            if (data_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_ready: got %b, expected 0", tag, data_busy);
            end
            checks++;
            if (data_fault !== exp_fault) begin
                errors++;
                $display("FAIL %s fault: got %b, expected %b", tag, data_fault, exp_fault);
            end
            if (!exp_fault) begin
                if (rd) begin
                    exp_din = model[idx];
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (be_eff[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
                    end
                end
            end
            checks++;
            if (data_in !== exp_din) begin
                errors++;
                $display("FAIL %s data_in: got %h, expected %h", tag, data_in, exp_din);
            end
        end

        step();
        checks++;
        if (data_ready !== 1'b0 || data_fault !== 1'b0 || data_in !== exp_din) begin
            errors++;
            $display("FAIL %s after_done: ready=%b fault=%b data_in=%h, expected 0 0 %h",
                     tag, data_ready, data_fault, data_in, exp_din);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if (data_in !== 32'h0 || data_ready !== 1'b0 || data_busy !== 1'b0 || data_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data_in=%h ready=%b busy=%b fault=%b, expected 0 0 0 0",
                     data_in, data_ready, data_busy, data_fault);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        exp_din = '0;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, "fill");
        end
    endtask

    task automatic test_directed();
        do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "write_10");
        do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "read_10");
        checks++;
        if (data_in !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_10_const: got %h, expected deadbeef", data_in);
        end
        do_txn(1'b1, 1'b0, 32'h12, 32'h0, 4'hF, 1'b0, "read_misalign");
        do_txn(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, "read_range");
        do_txn(1'b0, 1'b1, 32'h13, 32'h55555555, 4'hF, 1'b0, "write_misalign");
        do_txn(1'b0, 1'b1, 32'h8000_0010, 32'h66666666, 4'hF, 1'b0, "write_range");
        do_txn(1'b1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 1'b0, "conflict");
        do_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "read_after_faults");
        do_txn(1'b1, 1'b0, 32'h3FC, 32'h0, 4'hF, 1'b0, "read_top_word");
    endtask

    task automatic test_wait_disturb();
        for (int i = 0; i < 6; i++) begin
            do_txn(1'b0, 1'b1, 32'($urandom_range(0, DEPTH - 1) * 4), $urandom, 4'hF, 1'b1, "disturb_wr");
            do_txn(1'b1, 1'b0, 32'($urandom_range(0, DEPTH - 1) * 4), 32'h0, 4'hF, 1'b1, "disturb_rd");
        end
    endtask

    task automatic test_back_to_back();
        int unsigned a, b, n;
        a = $urandom_range(0, DEPTH - 1);
        b = (a + 1) % DEPTH;
        data_addr = 32'(a * 4);
        data_read = 1'b1;
        step();
        n = 0;
        while (!data_ready && n < RL + 5) begin
            step();
            n++;
        end
        checks++;
        if (!data_ready || n != RL || data_in !== model[a]) begin
            errors++;
            $display("FAIL b2b_first: ready=%b cycles=%0d data_in=%h, expected 1 %0d %h",
                     data_ready, n, data_in, RL, model[a]);
        end
        data_addr = 32'(b * 4);
        n = 0;
        do begin
            step();
            n++;
        end while (!data_ready && n < RL + 6);
        checks++;
        if (!data_ready || n != RL + 2 || data_in !== model[b]) begin
            errors++;
            $display("FAIL b2b_second: ready=%b period=%0d data_in=%h, expected 1 %0d %h",
                     data_ready, n, data_in, RL + 2, model[b]);
        end
        data_read = 1'b0;
        exp_din   = model[b];
        step();
        checks++;
        if (data_ready !== 1'b0 || data_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: ready=%b busy=%b, expected 0 0", data_ready, data_busy);
        end
    endtask

    task automatic test_reset_mid_write();
        do_txn(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, "pre_write_20");
        data_addr  = 32'h20;
        data_out   = 32'h12345678;
        data_write = 1'b1;
        step();
        data_write = 1'b0;
        checks++;
        if (data_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: got %b, expected 1", data_busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (data_busy !== 1'b0 || data_ready !== 1'b0 || data_in !== 32'h0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b ready=%b data_in=%h, expected 0 0 0",
                     data_busy, data_ready, data_in);
        end
        exp_din = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (data_ready !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_ready: got %b at cycle %0d, expected 0", data_ready, i);
            end
        end
        do_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, "midrst_readback");
        checks++;
        if (data_in !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL midrst_old_value: got %h, expected cafef00d", data_in);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int unsigned kind;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            case (kind)
                0, 1, 2, 3: do_txn(1'b0, 1'b1, addr, $urandom, 4'($urandom), 1'b0, "rand_wr");
                4, 5, 6, 7: do_txn(1'b1, 1'b0, addr, 32'h0, 4'($urandom), 1'b0, "rand_rd");
                8: do_txn(1'($urandom_range(0, 1)), 1'b1, addr | 32'($urandom_range(1, 3)),
                          $urandom, 4'hF, 1'b0, "rand_misalign");
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        do_txn(1'b1, 1'b0, ($urandom | 32'h400) & 32'hFFFF_FFFC, 32'h0, 4'hF, 1'b0, "rand_range");
                    else
                        do_txn(1'b1, 1'b1, addr, $urandom, 4'hF, 1'b0, "rand_conflict");
                end
            endcase
        end
    endtask

`ifdef DMEM_BYTE_EN_EN
    task automatic test_byte_en();
        do_txn(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'hF, 1'b0, "be_full");
        do_txn(1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0101, 1'b0, "be_0101");
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, "be_read");
        checks++;
        if (data_in !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL be_merge: got %h, expected aa22cc44", data_in);
        end
        do_txn(1'b0, 1'b1, 32'h40, 32'h99999999, 4'b0000, 1'b0, "be_none");
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, "be_none_read");
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_wait_disturb();
        test_back_to_back();
        test_reset_mid_write();
`ifdef DMEM_BYTE_EN_EN
        test_byte_en();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
